// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side FIFO behind a UART receiver. Each rising edge of
// in_valid is one push of a 10-bit entry {parity_err, stop_err, data}. The
// read side is first-word-fall-through. Overflow and error-count status can be
// cleared with clr_status.
//   clk, rst            clock and asynchronous active-high reset
//   in_data/in_valid    received byte and its valid level (edge-detected)
//   in_parity_err/in_stop_err  error flags, qualified by in_valid
//   out_data/out_perr/out_serr/out_valid/out_ready  FWFT head entry and pop handshake
//   count/full/empty    occupancy
//   overflow            sticky flag: a byte was lost because the FIFO was full
//   err_count           saturating count of errored bytes received
//   clr_status          clears overflow and err_count
module uart_rx_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter bit          DROP_ERRORED = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  input  logic                     in_parity_err,
  input  logic                     in_stop_err,
  output logic [7:0]               out_data,
  output logic                     out_perr,
  output logic                     out_serr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [7:0]               err_count,
  input  logic                     clr_status
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Elaboration-time guard on DEPTH.
  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two in 2..256");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_valid_q;
  logic          overflow_q, overflow_d;
  logic [7:0]    err_q, err_d;
  logic [9:0]    mem_q [DEPTH];
  logic [9:0]    head;

  logic push_req, has_err, store_req, pop, wr_en, lost, full_c, empty_c;

  // Next-state logic for pointers, occupancy and status.
  always_comb begin
    push_req   = in_valid & ~in_valid_q;
    has_err    = in_parity_err | in_stop_err;
    store_req  = push_req & ~(DROP_ERRORED & has_err);
    full_c     = (count_q == CW'(DEPTH));
    empty_c    = (count_q == '0);
    pop        = ~empty_c & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    wr_en      = store_req & (~full_c | pop);
    lost       = store_req & full_c & ~pop;

    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(wr_en) - CW'(pop);

    // Set/increment wins over a coincident clear.
    overflow_d = clr_status ? lost : (overflow_q | lost);
    err_d      = err_q;
    if (clr_status) begin
      err_d = 8'(push_req & has_err);
    end else if (push_req && has_err && err_q != 8'hFF) begin
      err_d = err_q + 8'd1;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_valid_q <= in_valid;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  // Storage array; contents are don't-care until written, outputs are gated by empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {in_parity_err, in_stop_err, in_data};
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_data  = empty_c ? 8'h00 : head[7:0];
  assign out_serr  = ~empty_c & head[8];
  assign out_perr  = ~empty_c & head[9];
  assign out_valid = ~empty_c;
  assign count     = count_q;
  assign full      = full_c;
  assign empty     = empty_c;
  assign overflow  = overflow_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo; two instances (DROP_ERRORED
// 0 and 1) share stimulus and are each compared against a queue-based model.
module tb_uart_rx_fifo;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] in_data;
  logic       in_valid, pe, se, ready, clr;

  logic [7:0]    od   [2];
  logic          operr[2];
  logic          oserr[2];
  logic          ov   [2];
  logic          fl   [2];
  logic          em   [2];
  logic          ovf  [2];
  logic [CW-1:0] cnt  [2];
  logic [7:0]    ec   [2];

  uart_rx_fifo #(.DEPTH(DEPTH), .DROP_ERRORED(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_parity_err(pe), .in_stop_err(se), .out_data(od[0]), .out_perr(operr[0]),
    .out_serr(oserr[0]), .out_valid(ov[0]), .out_ready(ready), .count(cnt[0]),
    .full(fl[0]), .empty(em[0]), .overflow(ovf[0]), .err_count(ec[0]),
    .clr_status(clr));

  uart_rx_fifo #(.DEPTH(DEPTH), .DROP_ERRORED(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_parity_err(pe), .in_stop_err(se), .out_data(od[1]), .out_perr(operr[1]),
    .out_serr(oserr[1]), .out_valid(ov[1]), .out_ready(ready), .count(cnt[1]),
    .full(fl[1]), .empty(em[1]), .overflow(ovf[1]), .err_count(ec[1]),
    .clr_status(clr));

  // Reference model: one queue of {perr, serr, data} per instance.
  logic [9:0] mq [2][$];
  bit         movf [2];
  int         mec  [2];
  bit         mprev;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      movf[k] = 1'b0;
      mec[k]  = 0;
    end
    mprev = 1'b0;
  endtask

  task automatic model_step();
    bit push, err, store, pop, lost;
    push = in_valid && !mprev;
    err  = push && (pe || se);
    for (int k = 0; k < 2; k++) begin
      pop   = (mq[k].size() != 0) && ready;
      store = push && !(k == 1 && err);
      lost  = store && (mq[k].size() == DEPTH) && !pop;
      if (clr)      mec[k] = err ? 1 : 0;
      else if (err) mec[k] = (mec[k] < 255) ? mec[k] + 1 : 255;
      movf[k] = clr ? lost : (movf[k] || lost);
      if (pop) void'(mq[k].pop_front());
      if (store && !lost) mq[k].push_back({pe, se, in_data});
    end
    mprev = in_valid;
  endtask

  task automatic compare_all();
    logic [9:0] h;
    for (int k = 0; k < 2; k++) begin
      h = (mq[k].size() != 0) ? mq[k][0] : 10'h000;
      check($sformatf("count%0d", k), int'(cnt[k]), mq[k].size());
      check($sformatf("empty%0d", k), int'(em[k]), int'(mq[k].size() == 0));
      check($sformatf("full%0d", k), int'(fl[k]), int'(mq[k].size() == DEPTH));
      check($sformatf("valid%0d", k), int'(ov[k]), int'(mq[k].size() != 0));
      check($sformatf("ovf%0d", k), int'(ovf[k]), int'(movf[k]));
      check($sformatf("errcnt%0d", k), int'(ec[k]), mec[k]);
      check($sformatf("data%0d", k), int'(od[k]), int'(h[7:0]));
      check($sformatf("serr%0d", k), int'(oserr[k]), int'(h[8]));
      check($sformatf("perr%0d", k), int'(operr[k]), int'(h[9]));
    end
  endtask

  // One clock: drive inputs, advance model, sample on the falling edge.
  task automatic step(input bit v, input logic [7:0] d, input bit p, input bit s,
                      input bit r, input bit c);
    in_valid = v; in_data = d; pe = p; se = s; ready = r; clr = c;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse(input logic [7:0] d, input bit p, input bit r);
    step(1'b1, d, p, 1'b0, r, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, r, 1'b0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset(input bit v_at_release);
    rst = 1'b1;
    in_valid = v_at_release; ready = 1'b0; clr = 1'b0; pe = 1'b0; se = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    in_data = 8'h00; in_valid = 1'b0; pe = 1'b0; se = 1'b0; ready = 1'b0; clr = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Held valid level: one push per byte, popped in order.
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h41 + b), 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++)  step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("cnt_after_hold", int'(cnt[0]), 0);

    // Overfill: 17 pushes, last lost, drain yields 0..15.
    for (int i = 0; i <= 16; i++) pulse(8'(i), 1'b0, 1'b0);
    check("full36", int'(fl[0]), 1);
    check("count36", int'(cnt[0]), 16);
    check("ovf36", int'(ovf[0]), 1);
    for (int i = 0; i < 16; i++) begin
      check("drain36", int'(od[0]), i);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("empty36", int'(em[0]), 1);

    // Full FIFO, push concurrent with pop.
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) pulse(8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
    check("count37", int'(cnt[0]), 16);
    check("ovf37", int'(ovf[0]), 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("last37", int'(od[0]), 8'hAA);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // Parity-errored byte: stored with flag, or dropped.
    do_reset(1'b0);
    pulse(8'h55, 1'b1, 1'b0);
    check("data38", int'(od[0]), 8'h55);
    check("perr38", int'(operr[0]), 1);
    check("ec38_0", int'(ec[0]), 1);
    check("empty38_1", int'(em[1]), 1);
    check("ec38_1", int'(ec[1]), 1);

    // Error counter saturation and clear priority.
    do_reset(1'b0);
    for (int i = 0; i < 300; i++) pulse(8'(i), 1'b1, 1'b1);
    check("ec39_sat", int'(ec[1]), 255);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ec39_clr", int'(ec[1]), 0);
    step(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    check("ec39_both", int'(ec[1]), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Mid-operation reset with 5 entries, then a clean push.
    for (int i = 0; i < 5; i++) pulse(8'(8'h60 + i), 1'b0, 1'b0);
    check("count40_pre", int'(cnt[0]), 5);
    do_reset(1'b0);
    check("empty40", int'(em[0]), 1);
    pulse(8'h7E, 1'b0, 1'b0);
    check("data40", int'(od[0]), 8'h7E);

    // in_valid already high at reset release: exactly one push.
    do_reset(1'b1);
    in_data = 8'h3C;
    for (int i = 0; i < 4; i++) step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    check("count34", int'(cnt[0]), 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset($urandom_range(0, 1) == 1);
      step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 49) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
